// File: rtl/npc_alu_pkg.sv
// Shared ALU definitions for the NPC core: comparator control codes and the
// compare request bundle exchanged between issue paths and the shared comparator.
package npc_alu_pkg;

    localparam int NPC_XLEN   = 64;
    localparam int CMP_CTRL_W = 4;
    localparam int CMP_TAGW   = 4;

    typedef enum logic [CMP_CTRL_W-1:0] {
        CMP_NEQ  = 4'd0,
        CMP_EQ   = 4'd1,
        CMP_GE_S = 4'd2,
        CMP_LT_S = 4'd3,
        CMP_LT_U = 4'd4
    } cmp_ctrl_e;

    typedef struct packed {
        logic [NPC_XLEN-1:0]   src1;
        logic [NPC_XLEN-1:0]   src2;
        logic [CMP_CTRL_W-1:0] ctrl;
        logic [CMP_TAGW-1:0]   tag;
    } cmp_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr_i,
// wrapping modulo NREQ. Grant is one-hot or all-zero.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  gnt_id_o
);

    always_comb begin
        int  idx;
        logic found;
        grant_o  = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                gnt_id_o     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin shared comparator: requesters feed an operand stage (S1), the
// compare result is registered in S2 which drives the response port directly.
module compare_arbiter
    import npc_alu_pkg::*;
#(
    parameter  int XLEN = 64,
    parameter  int NREQ = 2,
    parameter  int TAGW = 4,
    localparam int IDW  = ($clog2(NREQ) > 0) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*XLEN-1:0]   req_src1,
    input  logic [NREQ*XLEN-1:0]   req_src2,
    input  logic [NREQ*CMP_CTRL_W-1:0] req_ctrl,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [XLEN-1:0]        resp_result,
    output logic                   resp_illegal,
    output logic [IDW-1:0]         resp_id,
    output logic [TAGW-1:0]        resp_tag,
    output logic                   busy
);

    function automatic logic cmp_outcome(input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b,
                                         input logic [CMP_CTRL_W-1:0] ctrl);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (ctrl)
            CMP_NEQ:  return a != b;
            CMP_EQ:   return a == b;
            CMP_GE_S: return sa >= sb;
            CMP_LT_S: return sa < sb;
            CMP_LT_U: return a < b;
            default:  return 1'b0;
        endcase
    endfunction

    logic                  s1_vld_q, s1_vld_d;
    logic [XLEN-1:0]       s1_src1_q, s1_src1_d, s1_src2_q, s1_src2_d;
    logic [CMP_CTRL_W-1:0] s1_ctrl_q, s1_ctrl_d;
    logic [TAGW-1:0]       s1_tag_q, s1_tag_d;
    logic [IDW-1:0]        s1_id_q, s1_id_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [XLEN-1:0]       s2_result_q, s2_result_d;
    logic                  s2_illegal_q, s2_illegal_d;
    logic [IDW-1:0]        s2_id_q, s2_id_d;
    logic [TAGW-1:0]       s2_tag_q, s2_tag_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            s1_adv, s2_adv, accept;
    int              gi;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .grant_o  (grant),
        .gnt_id_o (gnt_id)
    );

    // resp_ready reaches req_ready combinationally so a full pipe still accepts every cycle
    assign s2_adv    = ~s2_vld_q | resp_ready;
    assign s1_adv    = ~s1_vld_q | s2_adv;
    assign req_ready = grant & {NREQ{s1_adv & ~flush & ~rst}};
    assign accept    = |req_ready;
    assign gi        = int'(gnt_id);

    always_comb begin
        s1_src1_d    = s1_src1_q;
        s1_src2_d    = s1_src2_q;
        s1_ctrl_d    = s1_ctrl_q;
        s1_tag_d     = s1_tag_q;
        s1_id_d      = s1_id_q;
        s2_result_d  = s2_result_q;
        s2_illegal_d = s2_illegal_q;
        s2_id_d      = s2_id_q;
        s2_tag_d     = s2_tag_q;
        rr_ptr_d     = rr_ptr_q;

        if (accept) begin
            s1_src1_d = req_src1[gi*XLEN +: XLEN];
            s1_src2_d = req_src2[gi*XLEN +: XLEN];
            s1_ctrl_d = req_ctrl[gi*CMP_CTRL_W +: CMP_CTRL_W];
            s1_tag_d  = req_tag[gi*TAGW +: TAGW];
            s1_id_d   = gnt_id;
            rr_ptr_d  = (gi == NREQ - 1) ? '0 : IDW'(gi + 1);
        end

        if (s1_vld_q && s2_adv) begin
            s2_result_d  = {{(XLEN-1){1'b0}}, cmp_outcome(s1_src1_q, s1_src2_q, s1_ctrl_q)};
            s2_illegal_d = (s1_ctrl_q > CMP_LT_U);
            s2_id_d      = s1_id_q;
            s2_tag_d     = s1_tag_q;
        end

        // Flush overrides both the new accept and the S1->S2 move
        s1_vld_d = flush ? 1'b0 : (accept | (s1_vld_q & ~s2_adv));
        s2_vld_d = flush ? 1'b0 : ((s1_vld_q & s2_adv) | (s2_vld_q & ~resp_ready));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_src1_q    <= '0;
            s1_src2_q    <= '0;
            s1_ctrl_q    <= '0;
            s1_tag_q     <= '0;
            s1_id_q      <= '0;
            s2_vld_q     <= 1'b0;
            s2_result_q  <= '0;
            s2_illegal_q <= 1'b0;
            s2_id_q      <= '0;
            s2_tag_q     <= '0;
            rr_ptr_q     <= '0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_src1_q    <= s1_src1_d;
            s1_src2_q    <= s1_src2_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_tag_q     <= s1_tag_d;
            s1_id_q      <= s1_id_d;
            s2_vld_q     <= s2_vld_d;
            s2_result_q  <= s2_result_d;
            s2_illegal_q <= s2_illegal_d;
            s2_id_q      <= s2_id_d;
            s2_tag_q     <= s2_tag_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign resp_valid   = s2_vld_q;
    assign resp_result  = s2_result_q;
    assign resp_illegal = s2_illegal_q;
    assign resp_id      = s2_id_q;
    assign resp_tag     = s2_tag_q;
    assign busy         = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: arbitration order, latency, backpressure,
// illegal codes, flush and asynchronous reset against hand-computed values.
module tb_compare_arbiter;

    localparam int XLEN = 64;
    localparam int NREQ = 2;
    localparam int TAGW = 4;
    localparam int IDW  = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_src1;
    logic [NREQ*XLEN-1:0] req_src2;
    logic [NREQ*4-1:0]    req_ctrl;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      resp_result;
    logic                 resp_illegal;
    logic [IDW-1:0]       resp_id;
    logic [TAGW-1:0]      resp_tag;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int nacc;
    int nt;
    int nrx;

    compare_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_ctrl     (req_ctrl),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_illegal (resp_illegal),
        .resp_id      (resp_id),
        .resp_tag     (resp_tag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] c, input logic [3:0] t);
        req_src1[i*XLEN +: XLEN] = a;
        req_src2[i*XLEN +: XLEN] = b;
        req_ctrl[i*4 +: 4]       = c;
        req_tag[i*TAGW +: TAGW]  = t;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; resp_ready = 1'b1;
        req_src1 = '0; req_src2 = '0; req_ctrl = '0; req_tag = '0;
        tick(); tick();
        req_valid = 2'b11; #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        req_valid = '0; rst = 1'b0;
        tick();

        // Contention: both requesters held valid, expect alternating grants
        set_req(0, 64'd3, 64'd3, 4'd1, 4'hA);
        set_req(1, 64'd3, 64'd3, 4'd0, 4'hB);
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 4) ? 2'b11 : 2'b00; #1;
            if (c < 4) chk("cont_grant", 64'(req_ready), ((c % 2) == 0) ? 64'd1 : 64'd2);
            tick();
            if (c >= 1 && c <= 4) begin
                chk("cont_valid", 64'(resp_valid), 64'd1);
                chk("cont_id", 64'(resp_id), 64'((c - 1) % 2));
                chk("cont_result", resp_result, (((c - 1) % 2) == 0) ? 64'd1 : 64'd0);
                chk("cont_tag", 64'(resp_tag), (((c - 1) % 2) == 0) ? 64'hA : 64'hB);
            end else if (c == 5) begin
                chk("cont_drained", 64'(resp_valid), 64'd0);
            end
        end

        // Single ops: -1 < 1 signed, but not unsigned
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3, 4'h5);
        req_valid = 2'b01; #1;
        chk("slt_ready", 64'(req_ready), 64'd1);
        tick(); req_valid = '0;
        chk("slt_lat1_valid", 64'(resp_valid), 64'd0);
        chk("slt_lat1_busy", 64'(busy), 64'd1);
        tick();
        chk("slt_valid", 64'(resp_valid), 64'd1);
        chk("slt_result", resp_result, 64'd1);
        chk("slt_id", 64'(resp_id), 64'd0);
        chk("slt_tag", 64'(resp_tag), 64'h5);
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 4'h6);
        req_valid = 2'b01;
        tick(); req_valid = '0;
        tick();
        chk("sltu_valid", 64'(resp_valid), 64'd1);
        chk("sltu_result", resp_result, 64'd0);
        chk("sltu_tag", 64'(resp_tag), 64'h6);

        // Illegal control code from requester 1 (pointer now at 1)
        set_req(1, 64'd5, 64'd5, 4'd7, 4'h9);
        req_valid = 2'b10; #1;
        chk("ill_ready", 64'(req_ready), 64'd2);
        tick(); req_valid = '0;
        tick();
        chk("ill_valid", 64'(resp_valid), 64'd1);
        chk("ill_result", resp_result, 64'd0);
        chk("ill_flag", 64'(resp_illegal), 64'd1);
        chk("ill_id", 64'(resp_id), 64'd1);
        chk("ill_tag", 64'(resp_tag), 64'h9);
        tick();

        // Backpressure: consumer stalls for 5 cycles under a stream on requester 0
        set_req(0, 64'd0, 64'd0, 4'd1, 4'h0);
        resp_ready = 1'b0; nacc = 0; nt = 0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 2'b01; req_tag[3:0] = 4'(nt); #1;
            if (req_ready[0]) begin nacc++; nt++; end
            tick();
            if (c >= 1) begin
                chk("bp_hold_valid", 64'(resp_valid), 64'd1);
                chk("bp_hold_tag", 64'(resp_tag), 64'd0);
                chk("bp_hold_result", resp_result, 64'd1);
            end
        end
        chk("bp_accepts", 64'(nacc), 64'd2);
        resp_ready = 1'b1; nrx = 0;
        for (int c = 0; c < 30 && nrx < 5; c++) begin
            req_valid = (nt < 5) ? 2'b01 : 2'b00; req_tag[3:0] = 4'(nt); #1;
            if (resp_valid) begin
                chk("bp_order_tag", 64'(resp_tag), 64'(nrx));
                chk("bp_order_id", 64'(resp_id), 64'd0);
                nrx++;
            end
            if (req_ready[0]) nt++;
            tick();
        end
        req_valid = '0;
        chk("bp_rx_count", 64'(nrx), 64'd5);
        chk("bp_idle", 64'(busy), 64'd0);

        // Flush with both stages full; pointer is at 1 before setup
        resp_ready = 1'b0;
        set_req(1, 64'd10, 64'd20, 4'd3, 4'h1);
        req_valid = 2'b10; #1;
        chk("fl_setup_a", 64'(req_ready), 64'd2);
        tick();
        set_req(0, 64'd20, 64'd10, 4'd3, 4'h2);
        req_valid = 2'b01; #1;
        chk("fl_setup_b", 64'(req_ready), 64'd1);
        tick();
        chk("fl_full_valid", 64'(resp_valid), 64'd1);
        flush = 1'b1; resp_ready = 1'b1; req_valid = 2'b11; #1;
        chk("fl_no_grant", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0; req_valid = '0;
        chk("fl_resp_valid", 64'(resp_valid), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        req_valid = 2'b11; #1;
        chk("fl_ptr_kept", 64'(req_ready), 64'd2);
        tick(); req_valid = '0;
        tick();
        chk("fl_after_id", 64'(resp_id), 64'd1);
        chk("fl_after_result", resp_result, 64'd1);
        tick();

        // Asynchronous reset with both stages full
        resp_ready = 1'b0;
        set_req(1, 64'd1, 64'd2, 4'd3, 4'hF);
        req_valid = 2'b10;
        tick(); tick();
        chk("rst2_pre_valid", 64'(resp_valid), 64'd1);
        chk("rst2_pre_tag", 64'(resp_tag), 64'hF);
        rst = 1'b1; #1;
        chk("rst2_valid", 64'(resp_valid), 64'd0);
        chk("rst2_result", resp_result, 64'd0);
        chk("rst2_illegal", 64'(resp_illegal), 64'd0);
        chk("rst2_id", 64'(resp_id), 64'd0);
        chk("rst2_tag", 64'(resp_tag), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0; req_valid = 2'b11; #1;
        chk("rst2_ptr", 64'(req_ready), 64'd1);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
